// File: rtl/reg_file.sv
// Parametrised register file: 1 write port with byte enables, 2 combinational read ports,
// synchronous bulk clear, optional hardwired-zero register 0.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en_reg,
  input  logic [AW-1:0]      w_addr,
  input  logic [WIDTH/8-1:0] byte_en,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [AW-1:0]      r_addr_a,
  input  logic [AW-1:0]      r_addr_b,
  output logic [WIDTH-1:0]   d_out_a,
  output logic [WIDTH-1:0]   d_out_b
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] merged;
  logic             wr_ok;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign lane_mask[8*i +: 8] = {8{byte_en[i]}};
  end

  // Word as it will look after this cycle's write: new lanes from d_in, the rest held.
  assign merged = (mem[w_addr] & ~lane_mask) | (d_in & lane_mask);
  assign wr_ok  = en_reg && !(ZERO_R0 && (w_addr == '0));

  // NOTE: every word is a flop with async reset so the whole file reads 0 during reset;
  // this rules out mapping the array onto a RAM macro, which cannot be reset in bulk.
  // NOTE: sequential state uses non-blocking assignments so all words update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[w_addr] <= merged;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = en_reg && !clr && rst;
`endif

  // NOTE: outputs get an unconditional default first so no path can infer a latch.
  always_comb begin
    d_out_a = mem[r_addr_a];
`ifdef REG_FILE_BYPASS_EN
    if (fwd_ok && (r_addr_a == w_addr)) d_out_a = merged;
`endif
    if (ZERO_R0 && (r_addr_a == '0)) d_out_a = '0;
  end

  always_comb begin
    d_out_b = mem[r_addr_b];
`ifdef REG_FILE_BYPASS_EN
    if (fwd_ok && (r_addr_b == w_addr)) d_out_b = merged;
`endif
    if (ZERO_R0 && (r_addr_b == '0)) d_out_b = '0;
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: default instance (ZERO_R0=1) plus a ZERO_R0=0 instance
// sharing the same stimulus; expectations follow REG_FILE_BYPASS_EN when it is defined.
`timescale 1ns/1ps
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        en_reg = 1'b0;
  logic [4:0]  w_addr = '0;
  logic [3:0]  byte_en = '0;
  logic [31:0] d_in = '0;
  logic [4:0]  r_addr_a = '0;
  logic [4:0]  r_addr_b = '0;
  logic [31:0] d_out_a, d_out_b, nz_out_a, nz_out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst), .clr(clr), .en_reg(en_reg), .w_addr(w_addr),
    .byte_en(byte_en), .d_in(d_in), .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
    .d_out_a(d_out_a), .d_out_b(d_out_b)
  );

  reg_file #(.ZERO_R0(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .clr(clr), .en_reg(en_reg), .w_addr(w_addr),
    .byte_en(byte_en), .d_in(d_in), .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
    .d_out_a(nz_out_a), .d_out_b(nz_out_b)
  );

  typedef struct {
    logic        clr;
    logic        en;
    logic [4:0]  wa;
    logic [3:0]  be;
    logic [31:0] d;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_nz_a;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, before the next rise.
  task automatic drive(input logic c, input logic e, input logic [4:0] wa, input logic [3:0] be,
                       input logic [31:0] d, input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clk);
    clr = c; en_reg = e; w_addr = wa; byte_en = be; d_in = d;
    r_addr_a = ra; r_addr_b = rb;
    #1;
  endtask

  initial begin
    // Rows never read the address being written, so they hold with or without forwarding.
    vecs[0]  = '{1'b0, 1'b1, 5'd5,  4'hF,    32'hDEADBEEF, 5'd6,  5'd1,  32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b0, 5'd0,  4'h0,    32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 5'd5,  4'b0101, 32'h11223344, 5'd1,  5'd2,  32'h0,        32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  4'h0,    32'h0,        5'd5,  5'd5,  32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44};
    vecs[4]  = '{1'b0, 1'b1, 5'd5,  4'h0,    32'hFFFFFFFF, 5'd1,  5'd2,  32'h0,        32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0,  4'h0,    32'h0,        5'd5,  5'd5,  32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44};
    vecs[6]  = '{1'b0, 1'b1, 5'd0,  4'hF,    32'hFFFFFFFF, 5'd5,  5'd1,  32'hDE22BE44, 32'h0,        32'hDE22BE44};
    vecs[7]  = '{1'b0, 1'b0, 5'd1,  4'h0,    32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFFFFFF};
    vecs[8]  = '{1'b0, 1'b1, 5'd31, 4'b1000, 32'hAB000000, 5'd5,  5'd30, 32'hDE22BE44, 32'h0,        32'hDE22BE44};
    vecs[9]  = '{1'b0, 1'b1, 5'd30, 4'b0011, 32'h0000CAFE, 5'd31, 5'd0,  32'hAB000000, 32'h0,        32'hAB000000};
    vecs[10] = '{1'b0, 1'b0, 5'd0,  4'h0,    32'h0,        5'd30, 5'd31, 32'h0000CAFE, 32'hAB000000, 32'h0000CAFE};

    // Power-up reset, with a write held across edges that must be dropped.
    drive(1'b0, 1'b1, 5'd5, 4'hF, 32'hFFFFFFFF, 5'd5, 5'd31);
    check("reset_a", d_out_a, 32'h0);
    check("reset_b", d_out_b, 32'h0);
    drive(1'b0, 1'b1, 5'd5, 4'hF, 32'hFFFFFFFF, 5'd5, 5'd5);
    @(negedge clk);
    rst = 1'b1; en_reg = 1'b0;
    #1;
    check("reset_write_dropped", d_out_a, 32'h0);
    check("reset_write_dropped_nz", nz_out_a, 32'h0);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].clr, vecs[i].en, vecs[i].wa, vecs[i].be, vecs[i].d, vecs[i].ra, vecs[i].rb);
      check($sformatf("vec%0d_a", i), d_out_a, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), d_out_b, vecs[i].exp_b);
      check($sformatf("vec%0d_nz_a", i), nz_out_a, vecs[i].exp_nz_a);
    end

    // Clear beats a simultaneous write; every address reads 0 afterwards.
    drive(1'b1, 1'b1, 5'd3, 4'hF, 32'h12345678, 5'd5, 5'd31);
    check("clr_pre_a", d_out_a, 32'hDE22BE44);
    check("clr_pre_b", d_out_b, 32'hAB000000);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'(i), 5'(31 - i));
      check($sformatf("clr_a%0d", i), d_out_a, 32'h0);
      check($sformatf("clr_b%0d", i), d_out_b, 32'h0);
      check($sformatf("clr_nz_a%0d", i), nz_out_a, 32'h0);
    end

    // Same-cycle forwarding (or its absence).
    drive(1'b0, 1'b1, 5'd7, 4'hF, 32'h0F0F0F0F, 5'd1, 5'd2);
    drive(1'b0, 1'b1, 5'd7, 4'hF, 32'hA5A5A5A5, 5'd7, 5'd7);
    check("byp_full_b", d_out_b, BYP ? 32'hA5A5A5A5 : 32'h0F0F0F0F);
    check("byp_full_a", d_out_a, BYP ? 32'hA5A5A5A5 : 32'h0F0F0F0F);
    drive(1'b0, 1'b1, 5'd7, 4'b0001, 32'h000000FF, 5'd6, 5'd7);
    check("byp_next_a", d_out_a, 32'h0);
    check("byp_lane_b", d_out_b, BYP ? 32'hA5A5A5FF : 32'hA5A5A5A5);
    drive(1'b0, 1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 5'd0, 5'd7);
    check("byp_zero_a", d_out_a, 32'h0);
    check("byp_zero_nz_a", nz_out_a, BYP ? 32'hFFFFFFFF : 32'h0);
    check("byp_hold_b", d_out_b, 32'hA5A5A5FF);
    drive(1'b1, 1'b1, 5'd7, 4'hF, 32'h11111111, 5'd7, 5'd7);
    check("byp_clr_gated", d_out_b, 32'hA5A5A5FF);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd7, 5'd0);
    check("byp_after_clr_a", d_out_a, 32'h0);
    check("byp_after_clr_nz_b", nz_out_b, 32'h0);

    // Mid-run asynchronous reset with nonzero contents.
    drive(1'b0, 1'b1, 5'd12, 4'hF, 32'hCAFEF00D, 5'd1, 5'd2);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd12, 5'd12);
    check("pre_rst_a", d_out_a, 32'hCAFEF00D);
    @(negedge clk);
    rst = 1'b0; en_reg = 1'b1; w_addr = 5'd9; byte_en = 4'hF; d_in = 32'hFFFFFFFF;
    #1;
    check("rst_async_a", d_out_a, 32'h0);
    check("rst_async_b", d_out_b, 32'h0);
    check("rst_async_nz_a", nz_out_a, 32'h0);
    drive(1'b0, 1'b1, 5'd9, 4'hF, 32'hFFFFFFFF, 5'd9, 5'd12);
    check("rst_hold_a", d_out_a, 32'h0);
    @(negedge clk);
    rst = 1'b1; en_reg = 1'b0; r_addr_a = 5'd9; r_addr_b = 5'd12;
    #1;
    check("rst_drop_a", d_out_a, 32'h0);
    check("rst_drop_b", d_out_b, 32'h0);
    drive(1'b0, 1'b1, 5'd9, 4'hF, 32'h00000012, 5'd10, 5'd11);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd9, 5'd9);
    check("post_rst_write_a", d_out_a, 32'h00000012);
    check("post_rst_write_b", d_out_b, 32'h00000012);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
